capture_sequencer: RTL
======================

# capture_sequencer

Frame-level scheduler for the single-channel 8-bit ADC capture driver on the imager board. On request it walks the pixel array row by row, steers the sensor row and column selects, waits a programmable settle time, triggers one ADC conversion per pixel through the driver's active-low start / chip-select handshake, and writes each sample into the frame buffer. It sits between the fabric control registers (frame request, status) and the ADC capture driver plus frame RAM.

## Interface
Parameters:
- `ADC_RES`, 8: sample width in bits.
- `NUM_COLS`, 112: pixels per row.
- `NUM_ROWS`, 112: rows per frame.
- `ADDR_W`, 14: frame buffer address width; must satisfy 2^ADDR_W ≥ NUM_COLS·NUM_ROWS.
- `SETTLE_TICKS`, 8: clk ticks held after a select change before triggering.
- `TIMEOUT_TICKS`, 64: max ticks waiting for `adcCs` to fall after trigger.

Ports:
- `clk`  in  1: system clock (20 MHz).
- `reset`  in  1: synchronous, active-high.
- `frameReq`  in  1: start a frame; sampled only in IDLE.
- `abort`  in  1: stop the current frame at the next pixel boundary.
- `busy`  out  1: high from frame start until return to IDLE.
- `frameDone`  out  1: one-cycle pulse when the last pixel is written.
- `err`  out  1: sticky conversion-timeout flag; cleared by `reset` or an accepted `frameReq`.
- `rowSel`  out  7: current row index.
- `colSel`  out  7: current column index.
- `startCapture`  out  1: to the ADC driver, active-low trigger.
- `adcCs`  in  1: driver chip select, low during conversion.
- `adcData`  in  ADC_RES: driver sample, valid while `adcCs` is high after a conversion.
- `wrEn`  out  1: frame buffer write strobe.
- `wrAddr`  out  ADDR_W: write address = row·NUM_COLS + col.
- `wrData`  out  ADC_RES: sample to write.

## Operation
- Reset values: `startCapture`=1, `busy`=0, `frameDone`=0, `err`=0, `wrEn`=0, `rowSel`=0, `colSel`=0, `wrAddr`=0, `wrData`=0, state=IDLE.
- IDLE: when `frameReq`=1, clear row, col, addr and `err`, set `busy`, and go to SETTLE.
- SETTLE: count SETTLE_TICKS cycles with the selects stable, then go to TRIG.
- TRIG: drive `startCapture`=0 and wait for `adcCs`=0.
  - On `adcCs`=0, release `startCapture`=1 and go to CONV.
  - If TIMEOUT_TICKS elapse first, set `err`, release the trigger, and go to DONE. No write occurs.
- CONV: wait for `adcCs`=1, then go to STORE.
- STORE: for one cycle, `wrEn`=1, `wrData`=`adcData`, `wrAddr`=current address.
- NEXT:
  - If `abort` was seen during the pixel, go to DONE without `frameDone`.
  - Else if col < NUM_COLS-1: col+1, addr+1.
  - Else col=0, row+1, addr+1.
  - After the last pixel (row=NUM_ROWS-1, col=NUM_COLS-1), pulse `frameDone` and go to DONE. Otherwise go to SETTLE.
- DONE: clear `busy` and return to IDLE. `rowSel` and `colSel` hold their last values.
- Address arithmetic is unsigned and incremental (no multiplier). It never wraps inside a frame.
- `abort` is latched on any cycle while `busy` and acted on in NEXT. A pixel already triggered always completes its conversion and its write.
- `frameReq` while `busy` is ignored, not queued.
- `reset` mid-frame returns everything to reset values on the next edge. `startCapture` goes high immediately, and the driver finishes its own conversion independently.

## Timing
- Per-pixel latency is SETTLE_TICKS + 1 (TRIG to `adcCs` fall) + conversion time + 1 (STORE) + 1 (NEXT).
- The driver's quiet interval is covered by SETTLE: the next trigger is at least SETTLE_TICKS after `adcCs` rises.
- `wrData` and `wrAddr` are registered and valid in the same cycle as `wrEn`.
- `frameDone` asserts in the cycle after the final `wrEn`. `busy` falls one cycle later.
- `startCapture` is low for exactly the TRIG duration (normally 1–2 cycles).

## Test plan
- Single frame, NUM_COLS=4, NUM_ROWS=3, with an ADC model returning row·16+col. Required: 12 writes, addr 0..11, data matches, one `frameDone` pulse, `busy` falls after it.
- ADC model holds `adcCs` high forever. Required: `err`=1 after 64 TRIG cycles, no `wrEn`, `busy` falls, `startCapture` returns to 1.
- `abort` pulsed during pixel 5. Required: pixel 5 written, no write at addr 6, no `frameDone`, return to IDLE.
- `frameReq` held high across a whole frame. Required: frames run back-to-back with exactly one IDLE cycle between them, and no request is accepted mid-frame.
- `reset` asserted during CONV. Required: all outputs at reset values on the next cycle. A following `frameReq` starts cleanly at addr 0.
- Row wrap at col=3→0. Required: `rowSel` increments in the same cycle that `colSel` goes to 0, and `wrAddr` stays contiguous (3→4).

Source files
------------

// File: rtl/capture_sequencer.sv
// capture_sequencer: frame-level scheduler for the 8-bit ADC capture driver.
// Walks rows/cols, settles, triggers one conversion per pixel, writes frame RAM.
module capture_sequencer #(
  parameter int ADC_RES       = 8,
  parameter int NUM_COLS      = 112,
  parameter int NUM_ROWS      = 112,
  parameter int ADDR_W        = 14,
  parameter int SETTLE_TICKS  = 8,
  parameter int TIMEOUT_TICKS = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frameReq,
  input  logic               abort,
  output logic               busy,
  output logic               frameDone,
  output logic               err,
  output logic [6:0]         rowSel,
  output logic [6:0]         colSel,
  output logic               startCapture,
  input  logic               adcCs,
  input  logic [ADC_RES-1:0] adcData,
  output logic               wrEn,
  output logic [ADDR_W-1:0]  wrAddr,
  output logic [ADC_RES-1:0] wrData
);

  localparam int MAX_TICKS =
    (TIMEOUT_TICKS > SETTLE_TICKS) ? TIMEOUT_TICKS : SETTLE_TICKS;
  localparam int CNT_W = $clog2(MAX_TICKS) + 1;

  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_TICKS - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_TICKS - 1);
  localparam logic [6:0]       COL_LAST     = 7'(NUM_COLS - 1);
  localparam logic [6:0]       ROW_LAST     = 7'(NUM_ROWS - 1);

  typedef enum logic [2:0] {
    IDLE, SETTLE, TRIG, CONV, STORE, NEXT, DONE
  } state_t;

  state_t state, state_n;

  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [ADDR_W-1:0]  addr, addr_n;
  logic [6:0]         row_n, col_n;
  logic               abort_q, abort_n;
  logic               busy_n, done_n, err_n;
  logic               wr_n, start_n;
  logic [ADDR_W-1:0]  wr_addr_n;
  logic [ADC_RES-1:0] wr_data_n;
  logic               last_px;

  assign last_px = (rowSel == ROW_LAST) && (colSel == COL_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      addr         <= '0;
      rowSel       <= '0;
      colSel       <= '0;
      abort_q      <= 1'b0;
      busy         <= 1'b0;
      frameDone    <= 1'b0;
      err          <= 1'b0;
      startCapture <= 1'b1;
      wrEn         <= 1'b0;
      wrAddr       <= '0;
      wrData       <= '0;
    end else begin
      cnt          <= cnt_n;
      addr         <= addr_n;
      rowSel       <= row_n;
      colSel       <= col_n;
      abort_q      <= abort_n;
      busy         <= busy_n;
      frameDone    <= done_n;
      err          <= err_n;
      startCapture <= start_n;
      wrEn         <= wr_n;
      wrAddr       <= wr_addr_n;
      wrData       <= wr_data_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    addr_n    = addr;
    row_n     = rowSel;
    col_n     = colSel;
    abort_n   = abort_q | (busy & abort);
    err_n     = err;
    done_n    = 1'b0;
    wr_n      = 1'b0;
    wr_addr_n = wrAddr;
    wr_data_n = wrData;

    unique case (state)
      IDLE: begin
        abort_n = 1'b0;
        if (frameReq) begin
          state_n = SETTLE;
          cnt_n   = '0;
          addr_n  = '0;
          row_n   = '0;
          col_n   = '0;
          err_n   = 1'b0;
        end
      end
      SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          state_n = TRIG;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      TRIG: begin
        if (!adcCs) begin
          state_n = CONV;
        end else if (cnt == TIMEOUT_LAST) begin
          state_n = DONE;
          err_n   = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      CONV: begin
        if (adcCs) begin
          state_n   = STORE;
          wr_n      = 1'b1;
          wr_addr_n = addr;
          wr_data_n = adcData;
        end
      end
      STORE: begin
        state_n = NEXT;
        // same abort view that NEXT will act on one cycle later
        done_n  = last_px && !abort_n;
      end
      NEXT: begin
        cnt_n = '0;
        if (abort_q || last_px) begin
          state_n = DONE;
        end else begin
          state_n = SETTLE;
          addr_n  = addr + 1'b1;
          if (colSel == COL_LAST) begin
            col_n = '0;
            row_n = rowSel + 1'b1;
          end else begin
            col_n = colSel + 1'b1;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
        abort_n = 1'b0;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n  = (state_n != IDLE) && (state_n != DONE);
    start_n = (state_n != TRIG);
  end

endmodule
